vga_fb_arbiter: RTL

Arbitrates a single-port framebuffer RAM between the VGA scan-out path and a host write port. It fetches one 3-bit colour cell per 4×4-pixel block ahead of the beam, using `hpos`/`vpos` from the hvsync generator. It presents a registered, position-aligned pixel colour to the colour output stage and grants host writes in every cycle not reserved for display. It sits between the hvsync generator, the framebuffer RAM and the d-ff colour register stage, all on the 25 MHz pixel clock.

---
 rtl/vga_fb_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch ahead of the beam, host writes in free slots.
// Produces a registered 3-bit pixel colour aligned to hpos/vpos.
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int COLS     = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        wr_valid,
    input  logic [14:0] wr_addr,
    input  logic [2:0]  wr_data,
    output logic        wr_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [2:0]  ram_wdata,
    input  logic [2:0]  ram_rdata,
    output logic [2:0]  pix_rgb
);

    localparam logic [9:0]  HA     = 10'(H_ACTIVE);
    localparam logic [9:0]  VA     = 10'(V_ACTIVE);
    localparam logic [9:0]  HT     = 10'(H_TOTAL);
    localparam logic [9:0]  VT     = 10'(V_TOTAL);
    localparam logic [14:0] CELLS  = 15'(COLS * (V_ACTIVE / 4));
    // Last in-line fetch slot loads the final column of the row
    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 7);

    logic [9:0]  next_line;
    logic        inline_slot;
    logic        pre_slot;
    logic        disp_slot;
    logic [7:0]  fetch_row;
    logic [7:0]  fetch_col;
    logic [14:0] row15;
    logic [14:0] fetch_addr;
    logic        host_go;
    logic        nx_active;

    logic        rd_q, rd_d;
    logic [2:0]  nxt_pix_q, nxt_pix_d;
    logic [2:0]  pix_q, pix_d;

    always_comb begin
        next_line   = (vpos == VT - 10'd1) ? 10'd0 : vpos + 10'd1;
        inline_slot = enable && (vpos < VA) && (hpos[1:0] == 2'd1)
                      && (hpos <= H_LAST);
        pre_slot    = enable && (hpos == HT - 10'd3) && (next_line < VA);
        disp_slot   = ~reset & (inline_slot | pre_slot);
        fetch_row   = pre_slot ? next_line[9:2] : vpos[9:2];
        fetch_col   = pre_slot ? 8'd0 : hpos[9:2] + 8'd1;
        row15       = {7'd0, fetch_row};
        fetch_addr  = (row15 << 7) + (row15 << 5) + {7'd0, fetch_col};
        wr_ready    = ~reset & ~disp_slot;
        host_go     = wr_valid & wr_ready & (wr_addr < CELLS);
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 15'd0;
        ram_wdata = 3'd0;
        if (disp_slot) begin
            ram_en   = 1'b1;
            ram_addr = fetch_addr;
        end else if (host_go) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end
    end

    // Next beam position decides whether the fetched cell is shown or blanked
    always_comb begin
        if (hpos == HT - 10'd1)
            nx_active = next_line < VA;
        else
            nx_active = (hpos < HA - 10'd1) && (vpos < VA);
        rd_d      = disp_slot;
        nxt_pix_d = rd_q ? ram_rdata : nxt_pix_q;
        pix_d     = pix_q;
        if (hpos[1:0] == 2'd3)
            pix_d = (enable && nx_active) ? nxt_pix_q : 3'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q      <= 1'b0;
            nxt_pix_q <= 3'd0;
            pix_q     <= 3'd0;
        end else begin
            rd_q      <= rd_d;
            nxt_pix_q <= nxt_pix_d;
            pix_q     <= pix_d;
        end
    end

    assign pix_rgb = pix_q;

endmodule
